spi_rx_frame_reader: RTL and testbench

- Drains the receive FIFO of spi_master or spi_slave through its o_fifo_out / i_read_enable / o_rx_empty interface.
- Packs consecutive received bytes into multi-byte frames and presents each frame downstream on a valid/ready handshake.
- Acts as the reader for the FIFO that the SPI core writes. Drops and flags partial frames that stall past a timeout.

---
 rtl/spi_pkg.sv | 8 +
 rtl/spi_idle_timer.sv | 20 ++
 rtl/spi_rx_frame_reader.sv | 89 ++++++++
 tb/tb_spi_rx_frame_reader.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM states, byte width and counter sizing for the SPI RX frame reader
package spi_pkg;
  localparam int SPI_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, COLLECT, CAPTURE, OUT} state_t;
  function automatic int cnt_w(input int bytes);
    return $clog2(bytes + 1);
  endfunction
endpackage

// File: rtl/spi_idle_timer.sv
// spi_idle_timer: counts enabled idle cycles and pulses o_tc on the TIMEOUT-th one (TIMEOUT=0 never fires)
module spi_idle_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign o_tc = (TIMEOUT != 0) && i_enable && (cnt_q == CW'(TIMEOUT - 1));
  // next count: restart on clear or expiry, otherwise advance while enabled
  always_comb cnt_d = (i_clear || o_tc) ? '0 : i_enable ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge i_clk)
    if (i_reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/spi_rx_frame_reader.sv
// spi_rx_frame_reader: pops SPI RX FIFO bytes, packs them into frames, hands frames out on valid/ready
module spi_rx_frame_reader
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int BYTES   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_MSB,
  input  logic                       i_rx_empty,
  input  logic                       i_rst_busy,
  input  logic [DATA_W-1:0]          i_fifo_data,
  output logic                       o_read_enable,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [BYTES*DATA_W-1:0]    o_word,
  output logic                       o_frame_err,
  output logic [cnt_w(BYTES)-1:0]    o_byte_cnt
);
  localparam int W  = BYTES * DATA_W;
  localparam int CW = cnt_w(BYTES);
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  word_q, word_d, base;
  logic          msb_q, msb_d;
  logic          pop, tc;
  // pops only while gathering, with data present and the core out of reset
  assign pop = (state_q == IDLE || state_q == COLLECT) && !i_rx_empty && !i_rst_busy;
  spi_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (state_q == CAPTURE),
    .i_enable (state_q == COLLECT && !pop),
    .o_tc     (tc)
  );
  assign o_read_enable = pop;
  assign o_valid       = state_q == OUT;
  assign o_word        = word_q;
  assign o_frame_err   = tc;
  assign o_byte_cnt    = cnt_q;
  // next state: pop, capture the byte one cycle later, hold full frame until accepted
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    msb_d   = msb_q;
    base    = (cnt_q == '0) ? '0 : word_q;
    unique case (state_q)
      IDLE, COLLECT: begin
        if (pop) begin
          state_d = CAPTURE;
          msb_d   = (cnt_q == '0) ? i_MSB : msb_q;
        end else if (tc) begin
          state_d = IDLE;
          cnt_d   = '0;
          word_d  = '0;
        end
      end
      CAPTURE: begin
        word_d  = msb_q ? (base << DATA_W) | W'(i_fifo_data)
                        : base | (W'(i_fifo_data) << (DATA_W * int'(cnt_q)));
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_d == CW'(BYTES)) ? OUT : COLLECT;
      end
      OUT: begin
        if (i_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and frame registers
  always_ff @(posedge i_clk)
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      msb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      msb_q   <= msb_d;
    end
endmodule

// File: tb/tb_spi_rx_frame_reader.sv
// tb_spi_rx_frame_reader: directed tests of frame packing, backpressure, timeout, reset and core-busy gating
module tb_spi_rx_frame_reader;
  logic        clk = 0, rst = 1, msb = 1, busy = 0, ready = 1;
  logic        rx_empty, re, valid, ferr;
  logic [7:0]  fifo_data = 0;
  logic [15:0] word;
  logic [1:0]  bcnt;
  logic [7:0]  mem [0:63];
  int          wr_ptr = 0, rd_ptr = 0, pops = 0, underflow = 0;
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  spi_rx_frame_reader #(.DATA_W(8), .BYTES(2), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_MSB(msb), .i_rx_empty(rx_empty), .i_rst_busy(busy),
    .i_fifo_data(fifo_data), .o_read_enable(re), .o_valid(valid), .i_ready(ready),
    .o_word(word), .o_frame_err(ferr), .o_byte_cnt(bcnt)
  );

  assign rx_empty = wr_ptr == rd_ptr;

  always @(posedge clk)
    if (re) begin
      pops <= pops + 1;
      if (wr_ptr == rd_ptr) underflow <= underflow + 1;
      else begin
        fifo_data <= mem[rd_ptr % 64];
        rd_ptr    <= rd_ptr + 1;
      end
    end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 64] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    n_checks++; if (re !== 1'b0) begin n_fail++; $display("FAIL reset_re got %b want 0", re); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    n_checks++; if (word !== 16'h0) begin n_fail++; $display("FAIL reset_word got %h want 0000", word); end
    n_checks++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", ferr); end
    n_checks++; if (bcnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", bcnt); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_msb_first;
    int n, p0;
    msb = 1; ready = 1; p0 = pops;
    push(8'hAA); push(8'h0F);
    wait_valid(n);
    n_checks++; if (n != 4) begin n_fail++; $display("FAIL msb_latency got %0d want 4", n); end
    n_checks++; if (word !== 16'hAA0F) begin n_fail++; $display("FAIL msb_word got %h want AA0F", word); end
    n_checks++; if (pops - p0 != 2) begin n_fail++; $display("FAIL msb_pops got %0d want 2", pops - p0); end
    @(negedge clk);
    n_checks++; if (valid !== 1'b0 || bcnt !== 2'd0) begin n_fail++; $display("FAIL msb_idle got valid=%b cnt=%0d want 0/0", valid, bcnt); end
  endtask

  task automatic test_lsb_first;
    int n;
    msb = 0; ready = 1;
    push(8'hAA); push(8'h0F);
    wait_valid(n);
    n_checks++; if (word !== 16'h0FAA || !valid) begin n_fail++; $display("FAIL lsb_word got %h valid=%b want 0FAA", word, valid); end
    @(negedge clk);
    msb = 1;
  endtask

  task automatic test_backpressure;
    int n, bad_re, bad_hold;
    ready = 0; bad_re = 0; bad_hold = 0;
    push(8'hF0); push(8'h88); push(8'h11); push(8'h22);
    wait_valid(n);
    n_checks++; if (word !== 16'hF088 || !valid) begin n_fail++; $display("FAIL bp_first got %h valid=%b want F088", word, valid); end
    repeat (20) begin
      @(negedge clk);
      if (re) bad_re++;
      if (!valid || word !== 16'hF088) bad_hold++;
    end
    n_checks++; if (bad_re != 0) begin n_fail++; $display("FAIL bp_no_pop got %0d pops want 0", bad_re); end
    n_checks++; if (bad_hold != 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles want 0", bad_hold); end
    n_checks++; if (wr_ptr - rd_ptr != 2) begin n_fail++; $display("FAIL bp_fifo_level got %0d want 2", wr_ptr - rd_ptr); end
    ready = 1;
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got valid=%b want 0", valid); end
    wait_valid(n);
    n_checks++; if (word !== 16'h1122 || !valid) begin n_fail++; $display("FAIL bp_second got %h valid=%b want 1122", word, valid); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int k, early;
    ready = 1; msb = 1; k = 0; early = 0;
    push(8'hCC);
    while (!ferr && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_checks++; if (k != 9) begin n_fail++; $display("FAIL to_delay got %0d want 9", k); end
    n_checks++; if (ferr !== 1'b1 || bcnt !== 2'd1) begin n_fail++; $display("FAIL to_pulse got err=%b cnt=%0d want 1/1", ferr, bcnt); end
    @(negedge clk);
    n_checks++; if (ferr !== 1'b0 || bcnt !== 2'd0) begin n_fail++; $display("FAIL to_after got err=%b cnt=%0d want 0/0", ferr, bcnt); end
    push(8'h12); push(8'h34);
    wait_valid(k);
    n_checks++; if (word !== 16'h1234 || !valid) begin n_fail++; $display("FAIL to_next got %h valid=%b want 1234", word, valid); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n;
    push(8'h55);
    repeat (2) @(negedge clk);
    n_checks++; if (bcnt !== 2'd1) begin n_fail++; $display("FAIL rm_partial got cnt=%0d want 1", bcnt); end
    rst = 1;
    @(negedge clk);
    n_checks++; if ({re, valid, word, ferr, bcnt} !== 21'd0) begin n_fail++; $display("FAIL rm_clear got re=%b v=%b w=%h e=%b c=%0d want all 0", re, valid, word, ferr, bcnt); end
    rst = 0;
    push(8'hA1); push(8'hB2);
    wait_valid(n);
    n_checks++; if (word !== 16'hA1B2 || !valid) begin n_fail++; $display("FAIL rm_fresh got %h valid=%b want A1B2", word, valid); end
    @(negedge clk);
  endtask

  task automatic test_busy;
    int n, bad;
    busy = 1; bad = 0;
    push(8'h77); push(8'h66);
    repeat (10) begin
      @(negedge clk);
      if (re) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL busy_hold got %0d pops want 0", bad); end
    busy = 0;
    #1;
    n_checks++; if (re !== 1'b1) begin n_fail++; $display("FAIL busy_resume got re=%b want 1", re); end
    wait_valid(n);
    n_checks++; if (word !== 16'h7766 || !valid) begin n_fail++; $display("FAIL busy_word got %h valid=%b want 7766", word, valid); end
    @(negedge clk);
    n_checks++; if (underflow != 0) begin n_fail++; $display("FAIL underflow got %0d want 0", underflow); end
  endtask

  initial begin
    test_reset;
    test_msb_first;
    test_lsb_first;
    test_backpressure;
    test_timeout;
    test_reset_mid;
    test_busy;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
